leb128_enc_stream: RTL and testbench
====================================

// Module: leb128_enc_stream
// PURPOSE
//  Streaming LEB128 encoder controller. Accepts 32-bit unsigned words on a valid/ready input.
//  Drives the packed chunks out one byte per cycle on a valid/ready byte stream.
//  Sits between a word producer and a byte-serial sink; it sequences the 7-bit chunking and
//  continuation-bit logic over multiple cycles and counts completed words.
// PARAMETERS
//  CNT_W   16   width of o_words completed-word counter (wraps modulo 2**CNT_W)
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst      in   1      reset, asynchronous, active-high
//  i_valid  in   1      input word valid
//  i_ready  out  1      input word accepted when i_valid & i_ready
//  i_data   in   32     word to encode
//  o_valid  out  1      output byte valid
//  o_ready  in   1      sink accepts byte when o_valid & o_ready
//  o_byte   out  8      encoded byte: {more, chunk[6:0]}
//  o_last   out  1      current o_byte is final byte of its word (more==0)
//  o_words  out  CNT_W  number of words fully emitted
//  busy     out  1      high while a word is held (state EMIT)
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, o_valid=0, o_byte=0, o_last=0, o_words=0, busy=0; in-flight word dropped.
//  - FSM: IDLE -> EMIT on input handshake; EMIT -> EMIT on each non-final byte handshake.
//  - EMIT -> IDLE on final byte handshake with no new input.
//  - EMIT -> EMIT (reload) on final byte handshake with concurrent input handshake.
//  - Length: n = max(1, ceil(msb_index+1)/7)), range 1..5; chunk k = data[7k+6:7k], chunk 4 = {3'b0, data[31:28]}.
//  - Accept: latch word into 35-bit shift reg sh, rem=n. First byte valid the cycle after the accept (latency 1).
//  - o_byte = {rem!=1, sh[6:0]}; o_last = (rem==1); o_valid = (state==EMIT).
//  - Byte handshake: sh >>= 7, rem -= 1. Final byte handshake: o_words += 1 (wraps).
//  - i_ready = (state==IDLE) | (state==EMIT & rem==1 & o_ready). Combinational from o_ready; zero-bubble back-to-back.
//  - o_valid=1 with o_ready=0: o_byte and o_last held stable, no state change (backpressure for any number of cycles).
//  - i_valid ignored while i_ready=0; i_data sampled only on input handshake.
//  - Width: 0 encodes as single 0x00; 0xFFFFFFFF as 5 bytes with top byte 0x0F (never >0x0F).
//  - o_words overflow: 2**CNT_W-1 + 1 -> 0, no flag.
//  - Reset asserted mid-word: outputs go to reset values immediately (async); no partial bytes after release.
// CONFIGURATION
//  LEB128_ZIGZAG_EN defined: i_data treated as signed two's complement, zigzag-mapped on accept:
//    z = {i_data[30:0],1'b0} ^ {32{i_data[31]}}; z is encoded as above.
//  LEB128_ZIGZAG_EN undefined: i_data encoded as unsigned, no mapping logic present.
// TESTING
//  1 i_data=0x00000000, o_ready=1 -> one byte 0x00, o_last=1, o_words 0->1.
//  2 i_data=300 (0x12C) -> 0xAC then 0x02 (o_last on 2nd); 0x7F -> 0x7F; 0x80 -> 0x80,0x01.
//  3 i_data=0xFFFFFFFF -> 0xFF,0xFF,0xFF,0xFF,0x0F on 5 consecutive cycles, busy high throughout.
//  4 words 0x80,0x05 back-to-back, o_ready=1: bytes 0x80,0x01,0x05 on consecutive cycles, i_ready high on cycle of 0x01.
//  5 o_ready low 3 cycles mid-word (0x3FFF): 0xFF held stable, then 0x7F on release; i_ready low throughout.
//  6 rst pulse after 2nd byte of 0xFFFFFFFF -> o_valid=0 at once, o_words=0, next word 0x01 -> single 0x01.
//  7 (LEB128_ZIGZAG_EN) i_data=-1 -> 0x01; -64 -> 0x7F; 64 -> 0x80,0x01.

Source files
------------

// File: rtl/leb128_enc_stream.sv
// Streaming LEB128 encoder: 32-bit words in, one {more, chunk[6:0]} byte per handshake out.
// Optional LEB128_ZIGZAG_EN: zigzag-map signed input words before encoding.
module leb128_enc_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [31:0]      i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [7:0]       o_byte,
    output logic             o_last,
    output logic [CNT_W-1:0] o_words,
    output logic             busy
);

    // Handshakes: a transfer happens on the rising edge where valid & ready are both high;
    // once o_valid rises, o_byte/o_last stay stable until the byte is taken.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [34:0] sh;
    logic [2:0]  rem;
    logic [31:0] word;
    logic [2:0]  len;
    logic        in_hs;
    logic        out_hs;
    logic        final_hs;

`ifdef LEB128_ZIGZAG_EN
    assign word = {i_data[30:0], 1'b0} ^ {32{i_data[31]}};
`else
    assign word = i_data;
`endif

    // Byte count follows the highest non-zero 7-bit group; zero still costs one byte.
    always_comb begin
        len = 3'd1;
        if (|word[31:28])
            len = 3'd5;
        else if (|word[27:21])
            len = 3'd4;
        else if (|word[20:14])
            len = 3'd3;
        else if (|word[13:7])
            len = 3'd2;
    end

    assign busy     = (state == EMIT);
    assign o_valid  = (state == EMIT);
    assign o_last   = (state == EMIT) && (rem == 3'd1);
    assign o_byte   = (state == EMIT) ? {rem != 3'd1, sh[6:0]} : 8'h00;
    assign i_ready  = (state == IDLE) || ((state == EMIT) && (rem == 3'd1) && o_ready);
    assign in_hs    = i_valid && i_ready;
    assign out_hs   = o_valid && o_ready;
    assign final_hs = out_hs && (rem == 3'd1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_hs) state_next = EMIT;
            EMIT: if (final_hs && !in_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A new word accepted alongside the final byte overwrites the shift register directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            rem <= '0;
        end else if (in_hs) begin
            sh  <= {3'b000, word};
            rem <= len;
        end else if (out_hs) begin
            sh  <= {7'd0, sh[34:7]};
            rem <= rem - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_words <= '0;
        else if (final_hs)
            o_words <= o_words + CNT_W'(1);
    end

endmodule

// File: tb/tb_leb128_enc_stream.sv
// Bench for leb128_enc_stream: directed vectors plus randomized words against an arithmetic LEB128 model.
// A small counter width makes the completed-word counter wrap within the run.
module tb_leb128_enc_stream;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             i_ready;
    logic [31:0]      i_data;
    logic             o_valid;
    logic             o_ready;
    logic [7:0]       o_byte;
    logic             o_last;
    logic [CNT_W-1:0] o_words;
    logic             busy;

    leb128_enc_stream #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_byte(o_byte), .o_last(o_last),
        .o_words(o_words), .busy(busy)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [8:0]       exp_q[$];
    logic [CNT_W-1:0] exp_words;
    logic [31:0]      in_q[$];
    logic [7:0]       cap_b[$];
    logic             cap_l[$];
    int               cap_c[$];
    logic             cap_r[$];
    logic             cap_busy[$];
    logic [7:0]       st_held[$];
    logic [7:0]       st_next[$];
    logic             st_irdy[$];
    logic             cap_to;
    logic             drv_to;

    // Reference: repeated divide-by-128, continuation bit set while anything remains.
    function automatic void model_push(input logic [31:0] w);
        logic [31:0] v;
        logic [6:0]  b;
`ifdef LEB128_ZIGZAG_EN
        longint s;
        s = longint'($signed(w));
        v = (s >= 0) ? 32'(2 * s) : 32'(-2 * s - 1);
`else
        v = w;
`endif
        do begin
            b = 7'(v % 128);
            v = v / 128;
            exp_q.push_back({v == 0, v != 0, b});
        end while (v != 0);
        exp_words = exp_words + CNT_W'(1);
    endfunction

    task automatic drive_words(input bit gaps);
        int  n;
        logic r;
        drv_to = 1'b0;
        for (int k = 0; k < in_q.size(); k++) begin
            if (gaps) begin
                i_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            i_valid = 1'b1;
            i_data  = in_q[k];
            n = 0;
            do begin
                @(negedge clk);
                r = i_ready;
                @(posedge clk); #1;
                n++;
            end while (!r && n < 2000);
            if (!r) drv_to = 1'b1;
        end
        i_valid = 1'b0;
        i_data  = $urandom;
    endtask

    // mode 0: sink always ready; 1: random sink; 2: three stall cycles on the first byte.
    task automatic capture(input int nbytes, input int mode);
        int   got = 0;
        int   cyc = 0;
        int   stalls = 3;
        logic pend = 1'b0;
        cap_b.delete(); cap_l.delete(); cap_c.delete(); cap_r.delete(); cap_busy.delete();
        st_held.delete(); st_next.delete(); st_irdy.delete();
        while (got < nbytes && cyc < 3000) begin
            @(posedge clk); #1;
            case (mode)
                0: o_ready = 1'b1;
                1: o_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (o_valid && stalls > 0) begin
                        o_ready = 1'b0;
                        stalls--;
                    end else begin
                        o_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            if (pend) begin
                st_next.push_back(o_byte);
                pend = 1'b0;
            end
            if (o_valid && o_ready) begin
                cap_b.push_back(o_byte);
                cap_l.push_back(o_last);
                cap_c.push_back(cyc);
                cap_r.push_back(i_ready);
                cap_busy.push_back(busy);
                got++;
            end else if (o_valid) begin
                st_held.push_back(o_byte);
                st_irdy.push_back(i_ready);
                pend = 1'b1;
            end
            cyc++;
        end
        cap_to = (got < nbytes);
        @(posedge clk); #1;
        o_ready = 1'b1;
    endtask

    task automatic test_reset;
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b want 0", o_valid); else pass_cnt++;
        chk_cnt++; if (o_byte !== 8'h00) $display("FAIL reset_o_byte: got %h want 00", o_byte); else pass_cnt++;
        chk_cnt++; if (o_last !== 1'b0) $display("FAIL reset_o_last: got %b want 0", o_last); else pass_cnt++;
        chk_cnt++; if (o_words !== '0) $display("FAIL reset_o_words: got %0d want 0", o_words); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (i_ready !== 1'b1) $display("FAIL reset_i_ready: got %b want 1", i_ready); else pass_cnt++;
    endtask

    task automatic test_zero;
        logic [8:0] e;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h0;
        model_push(32'h0);
        @(negedge clk);
        chk_cnt++; if (i_ready !== 1'b1) $display("FAIL zero_i_ready: got %b want 1", i_ready); else pass_cnt++;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        chk_cnt++; if (o_valid !== 1'b1) $display("FAIL zero_latency: o_valid got %b want 1", o_valid); else pass_cnt++;
        chk_cnt++; if ({o_last, o_byte} !== e) $display("FAIL zero_byte: got %h want %h", {o_last, o_byte}, e); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL zero_busy: got %b want 1", busy); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL zero_done_valid: got %b want 0", o_valid); else pass_cnt++;
        chk_cnt++; if (o_words !== exp_words) $display("FAIL zero_words: got %0d want %0d", o_words, exp_words); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string name);
        logic [8:0] e;
        chk_cnt++; if (cap_to !== 1'b0 || drv_to !== 1'b0) $display("FAIL %s_timeout: got cap=%b drv=%b want 0", name, cap_to, drv_to); else pass_cnt++;
        for (int i = 0; i < cap_b.size(); i++) begin
            e = exp_q.pop_front();
            chk_cnt++; if ({cap_l[i], cap_b[i]} !== e) $display("FAIL %s_byte%0d: got %h want %h", name, i, {cap_l[i], cap_b[i]}, e); else pass_cnt++;
        end
        chk_cnt++; if (o_words !== exp_words) $display("FAIL %s_words: got %0d want %0d", name, o_words, exp_words); else pass_cnt++;
        exp_q.delete();
    endtask

`ifndef LEB128_ZIGZAG_EN
    task automatic test_known;
        in_q = '{32'd300, 32'h7F, 32'h80, 32'hFFFFFFFF};
        exp_q = '{9'h0AC, 9'h102, 9'h17F, 9'h080, 9'h101,
                  9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h10F};
        exp_words = exp_words + CNT_W'(4);
        fork
            drive_words(1'b0);
            capture(10, 0);
        join
        for (int i = 5; i < cap_c.size(); i++) begin
            chk_cnt++; if (cap_busy[i] !== 1'b1) $display("FAIL known_busy%0d: got %b want 1", i, cap_busy[i]); else pass_cnt++;
        end
        for (int i = 1; i < cap_c.size(); i++) begin
            chk_cnt++; if (cap_c[i] !== cap_c[i-1] + 1) $display("FAIL known_gap%0d: got cycle %0d want %0d", i, cap_c[i], cap_c[i-1] + 1); else pass_cnt++;
        end
        check_stream("known");
    endtask
`else
    task automatic test_zigzag;
        in_q = '{32'hFFFFFFFF, 32'hFFFFFFC0, 32'h00000040};
        exp_q = '{9'h101, 9'h17F, 9'h080, 9'h101};
        exp_words = exp_words + CNT_W'(3);
        fork
            drive_words(1'b0);
            capture(4, 0);
        join
        check_stream("zigzag");
    endtask
`endif

    task automatic test_back_to_back;
        int n;
        in_q = '{32'h80, 32'h05};
        model_push(32'h80);
        model_push(32'h05);
        n = exp_q.size();
        fork
            drive_words(1'b0);
            capture(n, 0);
        join
        for (int i = 1; i < cap_c.size(); i++) begin
            chk_cnt++; if (cap_c[i] !== cap_c[i-1] + 1) $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, cap_c[i], cap_c[i-1] + 1); else pass_cnt++;
        end
        if (cap_r.size() > 1) begin
            chk_cnt++; if (cap_r[1] !== 1'b1) $display("FAIL b2b_i_ready: got %b want 1", cap_r[1]); else pass_cnt++;
        end
        check_stream("b2b");
    endtask

    task automatic test_backpressure;
        int n;
        logic [7:0] first;
        in_q = '{32'h3FFF};
        model_push(32'h3FFF);
        n = exp_q.size();
        first = exp_q[0][7:0];
        fork
            drive_words(1'b0);
            capture(n, 2);
        join
        chk_cnt++; if (st_held.size() !== 3) $display("FAIL bp_stalls: got %0d want 3", st_held.size()); else pass_cnt++;
        for (int i = 0; i < st_held.size(); i++) begin
            chk_cnt++; if (st_held[i] !== first || st_next[i] !== first) $display("FAIL bp_hold%0d: got %h/%h want %h", i, st_held[i], st_next[i], first); else pass_cnt++;
            chk_cnt++; if (st_irdy[i] !== 1'b0) $display("FAIL bp_i_ready%0d: got %b want 0", i, st_irdy[i]); else pass_cnt++;
        end
        check_stream("bp");
    endtask

    task automatic test_random;
        int n;
        logic [31:0] w;
        in_q.delete();
        for (int k = 0; k < 40; k++) begin
            w = $urandom >> $urandom_range(0, 32);
            if ($urandom_range(0, 9) == 0) w = 32'h0;
            if ($urandom_range(0, 9) == 0) w = 32'hFFFFFFFF;
            in_q.push_back(w);
            model_push(w);
        end
        n = exp_q.size();
        fork
            drive_words(1'b1);
            capture(n, 1);
        join
        for (int i = 0; i < st_held.size(); i++) begin
            if (st_held[i] !== st_next[i] || st_irdy[i] !== 1'b0) begin
                chk_cnt++;
                $display("FAIL rand_hold%0d: got %h->%h rdy %b want stable, rdy 0", i, st_held[i], st_next[i], st_irdy[i]);
            end else begin
                chk_cnt++; pass_cnt++;
            end
        end
        check_stream("rand");
    endtask

    task automatic test_reset_mid;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rstmid_o_valid: got %b want 0", o_valid); else pass_cnt++;
        chk_cnt++; if (o_words !== '0) $display("FAIL rstmid_o_words: got %0d want 0", o_words); else pass_cnt++;
        chk_cnt++; if (o_byte !== 8'h00 || busy !== 1'b0) $display("FAIL rstmid_out: got byte %h busy %b want 00 0", o_byte, busy); else pass_cnt++;
        @(posedge clk); #3;
        rst = 1'b0;
        exp_q.delete();
        exp_words = '0;
        @(posedge clk); #1;
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rstmid_release: o_valid got %b want 0", o_valid); else pass_cnt++;
        in_q = '{32'h01};
        model_push(32'h01);
        fork
            drive_words(1'b0);
            capture(1, 0);
        join
        check_stream("rstmid");
        @(negedge clk);
        chk_cnt++; if (o_valid !== 1'b0) $display("FAIL rstmid_tail: o_valid got %b want 0", o_valid); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 1'b0;
        i_data = 32'h0;
        o_ready = 1'b1;
        exp_words = '0;
        cap_to = 1'b0;
        drv_to = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_zero();
`ifndef LEB128_ZIGZAG_EN
        test_known();
`else
        test_zigzag();
`endif
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
